uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver. Supports run-time data length, parity, stop bits and baud divisor.
//  Uses 3-sample majority voting and reports framing, parity and break errors per character.
//  Characters go into a show-ahead FIFO drained with a valid/ready handshake.
//  Sits between the board RX pin and the host command parser; replaces the fixed 8N1 receiver.
// PARAMETERS
//  UART_DATA_WIDTH    8   max data bits per character (5..9); o_Rx_Byte width
//  CONFIG_DATA_WIDTH  32  width of the clocks-per-bit divisor word
//  FIFO_DEPTH         4   RX FIFO entries; power of 2, >=2
//  RESET_CPB          34  clocks-per-bit used out of reset until first config latch
// PORTS
//  i_Clock           in   1     system clock
//  i_Rst_n           in   1     asynchronous active-low reset
//  uart_config_data  in   CDW   clocks per bit (CPB); values <4 treated as 4
//  i_Data_Bits       in   4     data bits per char; clamped to [5, UART_DATA_WIDTH]
//  i_Parity_Mode     in   2     00 none, 01 odd, 10 even, 11 none
//  i_Two_Stop        in   1     1 = two stop bits checked
//  i_Rx_Serial       in   1     async serial line, idle high
//  o_Rx_Valid        out  1     FIFO head valid
//  i_Rx_Ready        in   1     consumer accepts head when o_Rx_Valid
//  o_Rx_Byte         out  UDW   head data, LSB = first bit received, unused MSBs 0
//  o_Frame_Err       out  1     head char had a stop bit sampled 0
//  o_Parity_Err      out  1     head char parity mismatch (0 when parity off)
//  o_Break           out  1     head char: all data, parity and stop samples 0
//  o_Overrun         out  1     1-cycle pulse: completed char dropped, FIFO full
//  o_Busy            out  1     FSM not in IDLE
// BEHAVIOUR
//  Reset: async assert, sync deassert. All outputs 0. FSM IDLE. FIFO empty. Synchroniser flops = 1. CPB = RESET_CPB.
//  Input: 2-flop synchroniser, then a 3-deep history of synchronised samples.
//   Vote = majority of last 3 synced samples. Pin-to-FSM latency is 2 cycles.
//  Config (CPB, bits, parity, stop) is latched only on the IDLE->START transition.
//   Changes mid-frame have no effect on that frame.
//  Bit counter: runs 0..CPB-1 per bit. Sample point is count == (CPB-1)>>1, using the vote.
//  States:
//   IDLE: synced sample 0 -> START, counter = 0.
//   START: at sample point, vote 0 -> DATA; vote 1 -> IDLE (glitch, nothing pushed).
//   DATA: sample each bit at its sample point, shift in LSB first.
//    After i_Data_Bits bits -> PARITY if parity enabled, else STOP.
//   PARITY: sample one bit. Parity error if XOR(data, parity bit) != (odd ? 1 : 0).
//   STOP: sample stop 1, then stop 2 if i_Two_Stop. Any stop sample 0 sets frame err.
//    At the last stop sample point, push {break, perr, ferr, data} to the FIFO.
//    Then go to IDLE if that sample was 1, else WAIT_HIGH.
//   WAIT_HIGH: stay until synced sample 1, then IDLE. Prevents retrigger during break.
//  Timing: o_Rx_Valid rises 1 cycle after the push, when the FIFO was empty.
//   Next start edge is accepted from the cycle after return to IDLE.
//  FIFO: show-ahead. o_Rx_Byte and the error flags reflect the head entry.
//   Pop when o_Rx_Valid && i_Rx_Ready. Pop while empty is ignored.
//  Full + push, no pop: char dropped, o_Overrun pulses 1 cycle, FIFO unchanged.
//  Full + push + pop same cycle: both happen, no overrun.
//  Empty + push + pop: the push is not visible until the next cycle, so no pop.
//  FIFO pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
//  Reset mid-frame: frame discarded, FIFO flushed, all outputs 0 immediately.
// TESTING
//  1. CPB=34, 8N1, send 0xA5, ready=1 -> one valid cycle, byte 0xA5, all error flags 0.
//  2. 7E2, send 0x41 with correct parity -> byte 0x41, perr=0.
//     Same char with parity bit flipped -> perr=1, ferr=0.
//  3. Line low for 10 bit times then high, 8N1 -> one entry, byte 0x00, ferr=1, break=1.
//     FSM waits for line high; no second entry.
//  4. 1-cycle low glitch on idle line -> no entry, o_Busy returns 0.
//     Single-cycle inverted spike at a data sample point -> byte unchanged (majority vote).
//  5. Ready held 0, send FIFO_DEPTH+1 chars -> first 4 retained in order, o_Overrun pulses once.
//     Repeat with a pop in the push cycle -> no overrun.
//  6. Assert i_Rst_n=0 mid-byte, release -> outputs 0, FIFO empty; next 0x3C is received cleanly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: majority-voted sampling, per-character
// error flags, and a show-ahead RX FIFO drained with a valid/ready handshake.
module uart_rx_cfg #(
   parameter int UART_DATA_WIDTH   = 8,
   parameter int CONFIG_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH        = 4,
   parameter int RESET_CPB         = 34
) (
   input  logic                         i_Clock,
   input  logic                         i_Rst_n,
   input  logic [CONFIG_DATA_WIDTH-1:0] uart_config_data,
   input  logic [3:0]                   i_Data_Bits,
   input  logic [1:0]                   i_Parity_Mode,
   input  logic                         i_Two_Stop,
   input  logic                         i_Rx_Serial,
   output logic                         o_Rx_Valid,
   input  logic                         i_Rx_Ready,
   output logic [UART_DATA_WIDTH-1:0]   o_Rx_Byte,
   output logic                         o_Frame_Err,
   output logic                         o_Parity_Err,
   output logic                         o_Break,
   output logic                         o_Overrun,
   output logic                         o_Busy
);

   localparam int UDW = UART_DATA_WIDTH;
   localparam int CDW = CONFIG_DATA_WIDTH;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int EW  = UDW + 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   // Input synchroniser and sample history
   logic       sync_meta;
   logic       sync_q;
   logic [1:0] hist_q;
   logic       vote;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         sync_meta <= 1'b1;
         sync_q    <= 1'b1;
         hist_q    <= 2'b11;
      end else begin
         sync_meta <= i_Rx_Serial;
         sync_q    <= sync_meta;
         hist_q    <= {hist_q[0], sync_q};
      end
   end

   assign vote = (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

   // Configuration as seen at the next start edge, with clamping applied
   logic [CDW-1:0] cfg_cpb;
   logic [3:0]     cfg_bits;

   always_comb begin
      cfg_cpb = uart_config_data;
      if (uart_config_data < CDW'(4)) cfg_cpb = CDW'(4);
      cfg_bits = i_Data_Bits;
      if (i_Data_Bits < 4'd5)            cfg_bits = 4'd5;
      else if (i_Data_Bits > 4'(UDW))    cfg_bits = 4'(UDW);
   end

   // Receive FSM state and per-frame registers
   state_t         state_q;
   logic [CDW-1:0] cnt_q;
   logic [CDW-1:0] cpb_q;
   logic [3:0]     bits_q;
   logic [1:0]     par_mode_q;
   logic           two_stop_q;
   logic [3:0]     bit_idx_q;
   logic [UDW-1:0] data_q;
   logic           par_bit_q;
   logic           ferr_q;
   logic           seen_one_q;
   logic           stop_idx_q;

   logic           last_cnt;
   logic           mid_cnt;
   logic           par_en;
   logic           par_odd;
   logic           last_stop;
   logic           push;
   logic [EW-1:0]  push_word;

   always_comb begin
      last_cnt  = (cnt_q == cpb_q - 1'b1);
      mid_cnt   = (cnt_q == ((cpb_q - 1'b1) >> 1));
      par_en    = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
      par_odd   = (par_mode_q == 2'b01);
      last_stop = !two_stop_q || stop_idx_q;
      push      = (state_q == S_STOP) && mid_cnt && last_stop;
      // Break: no sample of the whole frame (after start) was high
      push_word = {~(seen_one_q | vote),
                   par_en && ((^data_q ^ par_bit_q) != par_odd),
                   ferr_q | ~vote,
                   data_q};
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cpb_q      <= CDW'(RESET_CPB);
         bits_q     <= 4'(UDW);
         par_mode_q <= 2'b00;
         two_stop_q <= 1'b0;
         bit_idx_q  <= '0;
         data_q     <= '0;
         par_bit_q  <= 1'b0;
         ferr_q     <= 1'b0;
         seen_one_q <= 1'b0;
         stop_idx_q <= 1'b0;
      end else begin
         if (state_q != S_IDLE && state_q != S_WAIT_HIGH)
            cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               if (!sync_q) begin
                  state_q    <= S_START;
                  cnt_q      <= '0;
                  cpb_q      <= cfg_cpb;
                  bits_q     <= cfg_bits;
                  par_mode_q <= i_Parity_Mode;
                  two_stop_q <= i_Two_Stop;
                  bit_idx_q  <= '0;
                  data_q     <= '0;
                  par_bit_q  <= 1'b0;
                  ferr_q     <= 1'b0;
                  seen_one_q <= 1'b0;
                  stop_idx_q <= 1'b0;
               end
            end
            S_START: begin
               if (mid_cnt && vote)
                  state_q <= S_IDLE;
               else if (last_cnt)
                  state_q <= S_DATA;
            end
            S_DATA: begin
               if (mid_cnt) begin
                  for (int i = 0; i < UDW; i++)
                     if (bit_idx_q == 4'(i)) data_q[i] <= vote;
                  seen_one_q <= seen_one_q | vote;
               end
               if (last_cnt) begin
                  if (bit_idx_q == bits_q - 1'b1) begin
                     bit_idx_q <= '0;
                     state_q   <= par_en ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (mid_cnt) begin
                  par_bit_q  <= vote;
                  seen_one_q <= seen_one_q | vote;
               end
               if (last_cnt) state_q <= S_STOP;
            end
            S_STOP: begin
               if (mid_cnt) begin
                  if (last_stop) begin
                     state_q <= vote ? S_IDLE : S_WAIT_HIGH;
                  end else begin
                     ferr_q     <= ferr_q | ~vote;
                     seen_one_q <= seen_one_q | vote;
                  end
               end else if (last_cnt) begin
                  stop_idx_q <= 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               // Hold off until the line is released so a break cannot retrigger
               if (sync_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_Busy = (state_q != S_IDLE);

   // Show-ahead RX FIFO
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          fifo_full;
   logic          pop;
   logic          do_push;
   logic [EW-1:0] head;

   always_comb begin
      fifo_full = (count_q == CW'(FIFO_DEPTH));
      pop       = (count_q != '0) && i_Rx_Ready;
      do_push   = push && (!fifo_full || pop);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         o_Overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         o_Overrun <= push && fifo_full && !pop;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (do_push) mem[wr_ptr_q] <= push_word;
   end

   // Head fields are forced to 0 while empty so stale entries never leak out
   always_comb begin
      o_Rx_Valid   = (count_q != '0);
      head         = mem[rd_ptr_q];
      o_Rx_Byte    = o_Rx_Valid ? head[UDW-1:0] : '0;
      o_Frame_Err  = o_Rx_Valid & head[UDW];
      o_Parity_Err = o_Rx_Valid & head[UDW+1];
      o_Break      = o_Rx_Valid & head[UDW+2];
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames are driven bit by bit and the
// popped characters are compared against hand-computed expected words.
module tb_uart_rx_cfg;

   localparam int UDW   = 8;
   localparam int CDW   = 32;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [CDW-1:0] cfg_cpb;
   logic [3:0]     data_bits;
   logic [1:0]     parity_mode;
   logic           two_stop;
   logic           rx;
   logic           rx_ready;
   logic           rx_valid;
   logic [UDW-1:0] rx_byte;
   logic           frame_err;
   logic           parity_err;
   logic           brk;
   logic           overrun;
   logic           busy;

   uart_rx_cfg #(
      .UART_DATA_WIDTH  (UDW),
      .CONFIG_DATA_WIDTH(CDW),
      .FIFO_DEPTH       (DEPTH),
      .RESET_CPB        (34)
   ) dut (
      .i_Clock         (clk),
      .i_Rst_n         (rst_n),
      .uart_config_data(cfg_cpb),
      .i_Data_Bits     (data_bits),
      .i_Parity_Mode   (parity_mode),
      .i_Two_Stop      (two_stop),
      .i_Rx_Serial     (rx),
      .o_Rx_Valid      (rx_valid),
      .i_Rx_Ready      (rx_ready),
      .o_Rx_Byte       (rx_byte),
      .o_Frame_Err     (frame_err),
      .o_Parity_Err    (parity_err),
      .o_Break         (brk),
      .o_Overrun       (overrun),
      .o_Busy          (busy)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int failures  = 0;
   int bit_cyc   = 34;
   int ovr_cnt   = 0;
   int valid_cyc = 0;
   int snap;
   logic [UDW+2:0] got_q[$];
   logic [UDW+2:0] exp_q[$];

   // Observe handshakes and pulses away from the active edge
   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready)
         got_q.push_back({brk, parity_err, frame_err, rx_byte});
      if (overrun) ovr_cnt++;
      if (rx_valid) valid_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic score(input string tag);
      int n;
      logic [31:0] obs;
      n = exp_q.size();
      check({tag, "_count"}, got_q.size(), n);
      for (int i = 0; i < n; i++) begin
         obs = 32'hFFFF_FFFF;
         if (got_q.size() != 0) obs = {21'b0, got_q.pop_front()};
         check({tag, "_char"}, obs, {21'b0, exp_q.pop_front()});
      end
      got_q.delete();
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (bit_cyc) @(posedge clk);
      #1;
   endtask

   task automatic spike_bit(input logic b);
      rx = b;
      repeat (17) @(posedge clk);
      #1 rx = ~b;
      @(posedge clk);
      #1 rx = b;
      repeat (bit_cyc - 18) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] pm,
                             input logic ts, input logic flip, input int spike_at);
      logic p;
      @(posedge clk);
      #1;
      drive_bit(1'b0);
      p = 1'b0;
      for (int i = 0; i < nb; i++) begin
         p = p ^ d[i];
         if (i == spike_at) spike_bit(d[i]);
         else drive_bit(d[i]);
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         if (pm == 2'b01) p = ~p;
         drive_bit(p ^ flip);
      end
      drive_bit(1'b1);
      if (ts) drive_bit(1'b1);
   endtask

   task automatic set_8n1();
      data_bits   = 4'd8;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b0;
      cfg_cpb  = 34;
      set_8n1();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", rx_valid, 1'b0);
      check("rst_outs", {rx_byte, frame_err, parity_err, brk, overrun, busy}, '0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", busy, 1'b0);

      // 8N1 0xA5 with ready held high: exactly one valid cycle
      rx_ready = 1'b1;
      snap = valid_cyc;
      send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, -1);
      exp_q.push_back(11'h0A5);
      repeat (5) @(posedge clk);
      #1;
      score("8n1_a5");
      check("8n1_valid_cycles", valid_cyc - snap, 1);

      // 7E2: correct parity, then flipped parity bit
      data_bits = 4'd7; parity_mode = 2'b10; two_stop = 1'b1;
      send_frame(9'h041, 7, 2'b10, 1'b1, 1'b0, -1);
      exp_q.push_back(11'h041);
      send_frame(9'h041, 7, 2'b10, 1'b1, 1'b1, -1);
      exp_q.push_back(11'h241);
      repeat (5) @(posedge clk);
      #1;
      score("7e2");

      // 7O1 with the same data: odd parity bit is 1
      parity_mode = 2'b01; two_stop = 1'b0;
      send_frame(9'h041, 7, 2'b01, 1'b0, 1'b0, -1);
      exp_q.push_back(11'h041);
      repeat (5) @(posedge clk);
      #1;
      score("7o1");

      // Break: line low for ten bit times
      set_8n1();
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) drive_bit(1'b0);
      check("break_wait_busy", busy, 1'b1);
      rx = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      exp_q.push_back(11'h500);
      score("break");
      check("break_idle_busy", busy, 1'b0);

      // One-cycle glitch on the idle line
      rx = 1'b0;
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("glitch_busy", busy, 1'b0);
      score("glitch");

      // Inverted spike at a data sample point is voted away
      send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, 3);
      exp_q.push_back(11'h05A);
      repeat (5) @(posedge clk);
      #1;
      score("spike");

      // Different divisor latched at the start edge
      cfg_cpb = 16; bit_cyc = 16;
      send_frame(9'h0C3, 8, 2'b00, 1'b0, 1'b0, -1);
      exp_q.push_back(11'h0C3);
      repeat (5) @(posedge clk);
      #1;
      score("cpb16");
      cfg_cpb = 34; bit_cyc = 34;

      // Overrun: five characters into a four-entry FIFO
      rx_ready = 1'b0;
      snap = ovr_cnt;
      send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h033, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h044, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h055, 8, 2'b00, 1'b0, 1'b0, -1);
      repeat (5) @(posedge clk);
      #1;
      check("ovr_pulses", ovr_cnt - snap, 1);
      check("ovr_head_valid", rx_valid, 1'b1);
      check("ovr_head_byte", rx_byte, 8'h11);
      rx_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1 rx_ready = 1'b0;
      exp_q.push_back(11'h011);
      exp_q.push_back(11'h022);
      exp_q.push_back(11'h033);
      exp_q.push_back(11'h044);
      score("ovr_drain");

      // Full FIFO with a pop in the push cycle of the fifth character
      snap = ovr_cnt;
      send_frame(9'h061, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h062, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h063, 8, 2'b00, 1'b0, 1'b0, -1);
      send_frame(9'h064, 8, 2'b00, 1'b0, 1'b0, -1);
      fork
         send_frame(9'h065, 8, 2'b00, 1'b0, 1'b0, -1);
         begin
            @(posedge clk);
            repeat (325) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      repeat (5) @(posedge clk);
      #1;
      check("pushpop_no_ovr", ovr_cnt - snap, 0);
      rx_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1 rx_ready = 1'b0;
      exp_q.push_back(11'h061);
      exp_q.push_back(11'h062);
      exp_q.push_back(11'h063);
      exp_q.push_back(11'h064);
      exp_q.push_back(11'h065);
      score("pushpop");

      // Reset mid-frame with a character waiting in the FIFO
      send_frame(9'h077, 8, 2'b00, 1'b0, 1'b0, -1);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_valid", rx_valid, 1'b1);
      rx = 1'b0;
      repeat (3 * bit_cyc) @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {rx_valid, rx_byte, frame_err, parity_err, brk, overrun, busy}, '0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_valid", rx_valid, 1'b0);
      check("post_rst_busy", busy, 1'b0);
      rx_ready = 1'b1;
      send_frame(9'h03C, 8, 2'b00, 1'b0, 1'b0, -1);
      exp_q.push_back(11'h03C);
      repeat (5) @(posedge clk);
      #1;
      score("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
